// File: rtl/cpu_axi_master.sv
// cpu_axi_master: single-beat AXI master bridge for a CPU memory port; optional CPU_AXI_RESP_ERR_EN adds sticky error capture
module cpu_axi_master #(
  parameter logic [3:0] MASTER_ID = 4'd0,
  parameter int READ_ONLY = 0,
  parameter int AXI_ADDR_BITS = 32,
  parameter int AXI_DATA_BITS = 32,
  parameter int AXI_STRB_BITS = 4,
  parameter int AXI_ID_BITS = 4,
  parameter int AXI_LEN_BITS = 4,
  parameter int AXI_SIZE_BITS = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic req,
  input  logic we,
  input  logic [AXI_ADDR_BITS-1:0] addr,
  input  logic [AXI_DATA_BITS-1:0] wdata,
  input  logic [AXI_STRB_BITS-1:0] wstrb,
  output logic [AXI_DATA_BITS-1:0] rdata,
  output logic done,
  output logic stall,
  output logic [AXI_ID_BITS-1:0] ARID,
  output logic [AXI_ADDR_BITS-1:0] ARADDR,
  output logic [AXI_LEN_BITS-1:0] ARLEN,
  output logic [AXI_SIZE_BITS-1:0] ARSIZE,
  output logic [1:0] ARBURST,
  output logic ARVALID,
  input  logic ARREADY,
  input  logic [AXI_ID_BITS-1:0] RID,
  input  logic [AXI_DATA_BITS-1:0] RDATA,
  input  logic [1:0] RRESP,
  input  logic RLAST,
  input  logic RVALID,
  output logic RREADY,
  output logic [AXI_ID_BITS-1:0] AWID,
  output logic [AXI_ADDR_BITS-1:0] AWADDR,
  output logic [AXI_LEN_BITS-1:0] AWLEN,
  output logic [AXI_SIZE_BITS-1:0] AWSIZE,
  output logic [1:0] AWBURST,
  output logic AWVALID,
  input  logic AWREADY,
  output logic [AXI_DATA_BITS-1:0] WDATA,
  output logic [AXI_STRB_BITS-1:0] WSTRB,
  output logic WLAST,
  output logic WVALID,
  input  logic WREADY,
  input  logic [AXI_ID_BITS-1:0] BID,
  input  logic [1:0] BRESP,
  input  logic BVALID,
`ifdef CPU_AXI_RESP_ERR_EN
  output logic err,
  output logic [AXI_ADDR_BITS-1:0] err_addr,
`endif
  output logic BREADY
);
  typedef enum logic [2:0] {IDLE, RADDR, RDATA_S, WADDR, WRESP} state_t;
  localparam logic ro = READ_ONLY != 0;
  state_t state;
  logic [AXI_ADDR_BITS-1:0] addr_q;
  logic [AXI_DATA_BITS-1:0] wdata_q;
  logic [AXI_STRB_BITS-1:0] wstrb_q;
  logic arvalid_q, rready_q, awvalid_q, wvalid_q, bready_q;
  logic aw_ok, w_ok, unused;
  assign unused = &{1'b0, RID, BID, RRESP, BRESP};
  assign aw_ok = ~awvalid_q | AWREADY;
  assign w_ok = ~wvalid_q | WREADY;
  assign stall = req & ~done;
  assign ARID = AXI_ID_BITS'(MASTER_ID);
  assign ARADDR = addr_q;
  assign ARLEN = '0;
  assign ARSIZE = AXI_SIZE_BITS'(2);
  assign ARBURST = 2'b01;
  assign ARVALID = arvalid_q;
  assign RREADY = rready_q;
  assign AWID = ro ? '0 : AXI_ID_BITS'(MASTER_ID);
  assign AWADDR = ro ? '0 : addr_q;
  assign AWLEN = '0;
  assign AWSIZE = ro ? '0 : AXI_SIZE_BITS'(2);
  assign AWBURST = ro ? 2'b00 : 2'b01;
  assign AWVALID = ~ro & awvalid_q;
  assign WDATA = ro ? '0 : wdata_q;
  assign WSTRB = ro ? '0 : wstrb_q;
  assign WVALID = ~ro & wvalid_q;
  assign WLAST = ~ro & wvalid_q;
  assign BREADY = ~ro & bready_q;
  // One transaction at a time: accept in IDLE, walk the AXI channels, pulse done on the response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      addr_q <= '0;
      wdata_q <= '0;
      wstrb_q <= '0;
      arvalid_q <= 1'b0;
      rready_q <= 1'b0;
      awvalid_q <= 1'b0;
      wvalid_q <= 1'b0;
      bready_q <= 1'b0;
      done <= 1'b0;
      rdata <= '0;
`ifdef CPU_AXI_RESP_ERR_EN
      err <= 1'b0;
      err_addr <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (req & ~done & ~(we & ro)) begin
          addr_q <= addr;
          wdata_q <= wdata;
          wstrb_q <= wstrb;
          state <= we ? WADDR : RADDR;
          arvalid_q <= ~we;
          awvalid_q <= we;
          wvalid_q <= we;
        end
        RADDR: if (ARREADY) begin
          arvalid_q <= 1'b0;
          rready_q <= 1'b1;
          state <= RDATA_S;
        end
        RDATA_S: if (RVALID & RLAST) begin
          rdata <= RDATA;
          rready_q <= 1'b0;
          done <= 1'b1;
          state <= IDLE;
`ifdef CPU_AXI_RESP_ERR_EN
          if (RRESP != 2'b00) begin
            err <= 1'b1;
            err_addr <= addr_q;
          end
`endif
        end
        WADDR: begin
          if (AWREADY) awvalid_q <= 1'b0;
          if (WREADY) wvalid_q <= 1'b0;
          if (aw_ok & w_ok) begin
            bready_q <= 1'b1;
            state <= WRESP;
          end
        end
        WRESP: if (BVALID) begin
          bready_q <= 1'b0;
          done <= 1'b1;
          state <= IDLE;
`ifdef CPU_AXI_RESP_ERR_EN
          if (BRESP != 2'b00) begin
            err <= 1'b1;
            err_addr <= addr_q;
          end
`endif
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cpu_axi_master.sv
// tb_cpu_axi_master: directed checks of the single-beat AXI master bridge
module tb_cpu_axi_master;
  logic clk = 1'b0, rst = 1'b1;
  logic req = 1'b0, we = 1'b0;
  logic [31:0] addr = '0, wdata = '0, rdata;
  logic [3:0] wstrb = '0;
  logic done, stall;
  logic [3:0] ARID, AWID, RID = '0, BID = '0, ARLEN, AWLEN;
  logic [31:0] ARADDR, AWADDR, RDATA = '0, WDATA;
  logic [2:0] ARSIZE, AWSIZE;
  logic [1:0] ARBURST, AWBURST, RRESP = '0, BRESP = '0;
  logic ARVALID, ARREADY = 1'b0, RLAST = 1'b0, RVALID = 1'b0, RREADY;
  logic AWVALID, AWREADY = 1'b0, WLAST, WVALID, WREADY = 1'b0, BVALID = 1'b0, BREADY;
  logic [3:0] WSTRB;
`ifdef CPU_AXI_RESP_ERR_EN
  logic err;
  logic [31:0] err_addr;
`endif
  int checks = 0, failures = 0, done_cnt = 0, ar_cnt = 0;

  cpu_axi_master dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .addr(addr), .wdata(wdata), .wstrb(wstrb),
    .rdata(rdata), .done(done), .stall(stall),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID),
`ifdef CPU_AXI_RESP_ERR_EN
    .err(err), .err_addr(err_addr),
`endif
    .BREADY(BREADY)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (done) done_cnt++;
    if (ARVALID & ARREADY) ar_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  initial begin
    step;
    step;
    check("rst_arvalid", 32'(ARVALID), 0);
    check("rst_rready", 32'(RREADY), 0);
    check("rst_awvalid", 32'(AWVALID), 0);
    check("rst_wvalid", 32'(WVALID), 0);
    check("rst_bready", 32'(BREADY), 0);
    check("rst_done", 32'(done), 0);
    check("rst_rdata", rdata, 0);
    rst = 1'b0;
    step;
    // zero-wait read
    req = 1'b1; we = 1'b0; addr = 32'h10;
    #1 check("rd_stall_c0", 32'(stall), 1);
    step;
    check("rd_arvalid_c1", 32'(ARVALID), 1);
    check("rd_araddr", ARADDR, 32'h10);
    check("rd_arlen", 32'(ARLEN), 0);
    check("rd_arsize", 32'(ARSIZE), 2);
    check("rd_arburst", 32'(ARBURST), 1);
    check("rd_arid", 32'(ARID), 0);
    check("rd_stall_c1", 32'(stall), 1);
    ARREADY = 1'b1;
    step;
    check("rd_arvalid_c2", 32'(ARVALID), 0);
    check("rd_rready_c2", 32'(RREADY), 1);
    check("rd_stall_c2", 32'(stall), 1);
    ARREADY = 1'b0; RVALID = 1'b1; RLAST = 1'b1; RDATA = 32'hDEADBEEF;
    step;
    check("rd_done_c3", 32'(done), 1);
    check("rd_rdata", rdata, 32'hDEADBEEF);
    check("rd_stall_c3", 32'(stall), 0);
    check("rd_rready_c3", 32'(RREADY), 0);
    req = 1'b0; RVALID = 1'b0; RLAST = 1'b0;
    step;
    check("rd_done_c4", 32'(done), 0);
    // write with AW/W skew
    req = 1'b1; we = 1'b1; addr = 32'h0001_0004; wdata = 32'h1234_5678; wstrb = 4'b0011;
    step;
    check("wr_awvalid_c1", 32'(AWVALID), 1);
    check("wr_wvalid_c1", 32'(WVALID), 1);
    check("wr_wlast_c1", 32'(WLAST), 1);
    check("wr_awaddr", AWADDR, 32'h0001_0004);
    check("wr_wdata", WDATA, 32'h1234_5678);
    check("wr_wstrb", 32'(WSTRB), 3);
    check("wr_awsize", 32'(AWSIZE), 2);
    AWREADY = 1'b1;
    step;
    check("wr_awvalid_c2", 32'(AWVALID), 0);
    check("wr_wvalid_c2", 32'(WVALID), 1);
    AWREADY = 1'b0;
    step;
    check("wr_wvalid_c3", 32'(WVALID), 1);
    check("wr_bready_c3", 32'(BREADY), 0);
    step;
    check("wr_wvalid_c4", 32'(WVALID), 1);
    WREADY = 1'b1;
    step;
    check("wr_wvalid_c5", 32'(WVALID), 0);
    check("wr_bready_c5", 32'(BREADY), 1);
    check("wr_done_c5", 32'(done), 0);
    WREADY = 1'b0; BVALID = 1'b1;
    step;
    check("wr_done_c6", 32'(done), 1);
    check("wr_rdata_kept", rdata, 32'hDEADBEEF);
    check("wr_bready_c6", 32'(BREADY), 0);
    req = 1'b0; BVALID = 1'b0; we = 1'b0;
    step;
    // read with five AR wait cycles and a toggling CPU address
    req = 1'b1; addr = 32'h10;
    step;
    for (int i = 1; i <= 5; i++) begin
      check($sformatf("bp_arvalid_c%0d", i), 32'(ARVALID), 1);
      check($sformatf("bp_araddr_c%0d", i), ARADDR, 32'h10);
      addr = addr ^ 32'hFFFF_FF00;
      step;
    end
    check("bp_arvalid_c6", 32'(ARVALID), 1);
    ARREADY = 1'b1;
    step;
    check("bp_rready_c7", 32'(RREADY), 1);
    check("bp_done_c7", 32'(done), 0);
    ARREADY = 1'b0; RVALID = 1'b1; RLAST = 1'b1; RDATA = 32'hCAFE_F00D;
    step;
    check("bp_done_c8", 32'(done), 1);
    check("bp_rdata", rdata, 32'hCAFE_F00D);
    req = 1'b0; RVALID = 1'b0; RLAST = 1'b0;
    step;
    // back-to-back read then write with req held, plus a discarded non-last beat
    done_cnt = 0; ar_cnt = 0;
    req = 1'b1; we = 1'b0; addr = 32'h20;
    step;
    ARREADY = 1'b1;
    step;
    ARREADY = 1'b0; RVALID = 1'b1; RLAST = 1'b0; RDATA = 32'h1111_1111;
    step;
    check("bb_rready_nonlast", 32'(RREADY), 1);
    check("bb_done_nonlast", 32'(done), 0);
    check("bb_rdata_nonlast", rdata, 32'hCAFE_F00D);
    RLAST = 1'b1; RDATA = 32'h2222_2222;
    step;
    check("bb_rd_done", 32'(done), 1);
    check("bb_rdata", rdata, 32'h2222_2222);
    RVALID = 1'b0; RLAST = 1'b0; we = 1'b1; addr = 32'h30; wdata = 32'hA5A5_A5A5; wstrb = 4'hF;
    step;
    check("bb_no_dup_ar", 32'(ARVALID), 0);
    check("bb_aw_not_yet", 32'(AWVALID), 0);
    step;
    check("bb_awvalid", 32'(AWVALID), 1);
    check("bb_wvalid", 32'(WVALID), 1);
    AWREADY = 1'b1; WREADY = 1'b1;
    step;
    check("bb_bready", 32'(BREADY), 1);
    AWREADY = 1'b0; WREADY = 1'b0; BVALID = 1'b1;
    step;
    check("bb_wr_done", 32'(done), 1);
    BVALID = 1'b0; req = 1'b0; we = 1'b0;
    step;
    step;
    check("bb_done_count", 32'(done_cnt), 2);
    check("bb_ar_count", 32'(ar_cnt), 1);
    // reset in the middle of a read
    req = 1'b1; addr = 32'h40;
    step;
    ARREADY = 1'b1;
    step;
    ARREADY = 1'b0;
    check("mr_rready_before", 32'(RREADY), 1);
    rst = 1'b1;
    #2;
    check("mr_rready_async", 32'(RREADY), 0);
    check("mr_done_async", 32'(done), 0);
    check("mr_rdata_cleared", rdata, 0);
    req = 1'b0;
    step;
    rst = 1'b0;
    step;
    req = 1'b1; addr = 32'h44;
    step;
    check("mr2_araddr", ARADDR, 32'h44);
    ARREADY = 1'b1;
    step;
    ARREADY = 1'b0; RVALID = 1'b1; RLAST = 1'b1; RDATA = 32'h5555_AAAA;
    step;
    check("mr2_done", 32'(done), 1);
    check("mr2_rdata", rdata, 32'h5555_AAAA);
    req = 1'b0; RVALID = 1'b0; RLAST = 1'b0;
    step;
`ifdef CPU_AXI_RESP_ERR_EN
    req = 1'b1; addr = 32'h4000_0000;
    step;
    ARREADY = 1'b1;
    step;
    ARREADY = 1'b0; RVALID = 1'b1; RLAST = 1'b1; RRESP = 2'b11; RDATA = 32'h0BAD_0BAD;
    step;
    check("err_set", 32'(err), 1);
    check("err_addr", err_addr, 32'h4000_0000);
    check("err_rdata", rdata, 32'h0BAD_0BAD);
    req = 1'b0; RVALID = 1'b0; RLAST = 1'b0; RRESP = 2'b00;
    step;
    req = 1'b1; addr = 32'h50;
    step;
    ARREADY = 1'b1;
    step;
    ARREADY = 1'b0; RVALID = 1'b1; RLAST = 1'b1;
    step;
    check("err_sticky", 32'(err), 1);
    check("err_addr_kept", err_addr, 32'h4000_0000);
    req = 1'b0; RVALID = 1'b0; RLAST = 1'b0;
    step;
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
